cpu_run_monitor: RTL and testbench

- Synthesizable run-supervision block that watches a VeriRISC-class CPU running a diagnostic program.
- Counts fetched instructions and records a bounded PC/opcode/ALU trace.
- Enforces a cycle-budget watchdog and checks the halt PC against an expected value.
- Sits beside the `cpu` instance in both simulation and FPGA bring-up, so that self-check no longer depends on bench-only code.

---
 rtl/cpu_mon_pkg.sv | 23 ++
 rtl/cpu_run_monitor_trace_fifo.sv | 73 +++++++
 rtl/cpu_run_monitor.sv | 153 +++++++++++++++
 tb/tb_cpu_run_monitor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mon_pkg.sv
// Shared types for the CPU run monitor: FSM states, failure codes and the
// trace entry layout (defaults match the VeriRISC-class core).
package cpu_mon_pkg;

  localparam int MON_PC_W   = 5;
  localparam int MON_OP_W   = 3;
  localparam int MON_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} mon_state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_PC      = 2'd1,
    FC_TIMEOUT = 2'd2
  } fail_code_t;

  typedef struct packed {
    logic [MON_PC_W-1:0]   pc;
    logic [MON_OP_W-1:0]   opcode;
    logic [MON_DATA_W-1:0] alu_out;
  } trace_entry_t;

endpackage

// File: rtl/cpu_run_monitor_trace_fifo.sv
// Circular trace buffer: overwrites the oldest entry when full, one-cycle
// read latency, occupancy count and a sticky overflow flag reset by clear.
module trace_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic                     o_rd_valid,
  output logic [W-1:0]             o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic          r_rd_valid;
  logic [W-1:0]  r_rd_data;

  logic w_full;
  logic w_pop;

  assign w_full = (r_count == (AW+1)'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  // Storage write; contents need no reset since pointers define validity.
  // When full, wr and rd pointers coincide, so a push overwrites the oldest.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_clear) r_mem[r_wr] <= i_din;
  end

  // Pointer, count, overflow and read-port control.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (i_clear) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      // Read sees the pre-write slot value, so pop+push on full is safe.
      if (w_pop) r_rd_data <= r_mem[r_rd];
      if (i_push) r_wr <= r_wr + AW'(1);
      // A push into a full buffer without a pop drops the oldest entry.
      if (w_pop || (i_push && w_full)) r_rd <= r_rd + AW'(1);
      if (i_push && w_full && !w_pop) r_ovf <= 1'b1;
      if (i_push && !w_pop && !w_full)  r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !i_push)        r_count <= r_count - (AW+1)'(1);
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_count    = r_count;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/cpu_run_monitor.sv
// Run supervisor for a VeriRISC-class CPU: counts fetches, traces
// {pc, opcode, alu_out}, enforces a cycle-budget watchdog and checks halt PC.
module cpu_run_monitor
  import cpu_mon_pkg::*;
#(
  parameter int PC_W        = MON_PC_W,
  parameter int OP_W        = MON_OP_W,
  parameter int DATA_W      = MON_DATA_W,
  parameter int TRACE_DEPTH = 16,
  parameter int CNT_W       = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_start,
  input  logic [PC_W-1:0]                 i_exp_pc,
  input  logic [CNT_W-1:0]                i_max_cycles,
  input  logic                            i_load_ir,
  input  logic                            i_halt,
  input  logic [PC_W-1:0]                 i_pc,
  input  logic [OP_W-1:0]                 i_opcode,
  input  logic [DATA_W-1:0]               i_alu_out,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_pass,
  output logic [1:0]                      o_fail_code,
  output logic [PC_W-1:0]                 o_final_pc,
  output logic [CNT_W-1:0]                o_instr_count,
  input  logic                            i_tr_rd_en,
  output logic                            o_tr_rd_valid,
  output logic [PC_W+OP_W+DATA_W-1:0]     o_tr_rd_data,
  output logic [$clog2(TRACE_DEPTH):0]    o_tr_count,
  output logic                            o_tr_overflow
);
  localparam int TW = PC_W + OP_W + DATA_W;

  mon_state_t       r_state;
  fail_code_t       r_fail;
  logic             r_load_q;
  logic             r_halt_q;
  logic [PC_W-1:0]  r_exp_pc;
  logic [CNT_W-1:0] r_max;
  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_instr;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [PC_W-1:0]  r_final_pc;

  logic          w_run;
  logic          w_start_ok;
  logic          w_cap;
  logic          w_halt_edge;
  logic          w_wdog;
  logic [TW-1:0] w_entry;

  assign w_run       = (r_state == RUN);
  assign w_start_ok  = i_start && !w_run;
  assign w_cap       = w_run && i_load_ir && !r_load_q;
  assign w_halt_edge = w_run && i_halt && !r_halt_q;
  assign w_wdog      = w_run && (r_max != '0) && (r_cyc == r_max - CNT_W'(1));
  assign w_entry     = {i_pc, i_opcode, i_alu_out};

  // Previous-cycle copies of the CPU level strobes for edge detection.
  // Tracked in every state so a halt already high at start is not an edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_load_q <= 1'b0;
      r_halt_q <= 1'b0;
    end else begin
      r_load_q <= i_load_ir;
      r_halt_q <= i_halt;
    end
  end

  // Run FSM with registered status outputs; halt edge outranks the watchdog.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= IDLE;
      r_fail     <= FC_NONE;
      r_exp_pc   <= '0;
      r_max      <= '0;
      r_cyc      <= '0;
      r_instr    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_final_pc <= '0;
    end else begin
      case (r_state)
        RUN: begin
          r_cyc <= r_cyc + CNT_W'(1);
          if (w_cap && (r_instr != '1)) r_instr <= r_instr + CNT_W'(1);
          if (w_halt_edge) begin
            r_final_pc <= i_pc;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            if (i_pc == r_exp_pc) begin
              r_state <= PASS;
              r_pass  <= 1'b1;
              r_fail  <= FC_NONE;
            end else begin
              r_state <= FAIL;
              r_pass  <= 1'b0;
              r_fail  <= FC_PC;
            end
          end else if (w_wdog) begin
            r_state    <= FAIL;
            r_final_pc <= i_pc;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_pass     <= 1'b0;
            r_fail     <= FC_TIMEOUT;
          end
        end
        default: begin
          if (w_start_ok) begin
            r_state    <= RUN;
            r_exp_pc   <= i_exp_pc;
            r_max      <= i_max_cycles;
            r_cyc      <= '0;
            r_instr    <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail     <= FC_NONE;
            r_final_pc <= '0;
          end
        end
      endcase
    end
  end

  trace_fifo #(.W(TW), .DEPTH(TRACE_DEPTH)) u_trace (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (w_start_ok),
    .i_push     (w_cap),
    .i_din      (w_entry),
    .i_pop      (i_tr_rd_en),
    .o_rd_valid (o_tr_rd_valid),
    .o_rd_data  (o_tr_rd_data),
    .o_count    (o_tr_count),
    .o_overflow (o_tr_overflow)
  );

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_pass        = r_pass;
  assign o_fail_code   = r_fail;
  assign o_final_pc    = r_final_pc;
  assign o_instr_count = r_instr;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor with hand-computed expectations.
module tb_cpu_run_monitor;
  import cpu_mon_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst, i_start, i_load_ir, i_halt, i_tr_rd_en;
  logic [4:0]  i_exp_pc, i_pc;
  logic [15:0] i_max_cycles;
  logic [2:0]  i_opcode;
  logic [7:0]  i_alu_out;
  logic        o_busy, o_done, o_pass, o_tr_rd_valid, o_tr_overflow;
  logic [1:0]  o_fail_code;
  logic [4:0]  o_final_pc;
  logic [15:0] o_instr_count;
  logic [15:0] o_tr_rd_data;
  logic [4:0]  o_tr_count;

  int n_chk = 0;
  int n_pass = 0;

  always #5 i_clk = ~i_clk;

  cpu_run_monitor dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_exp_pc(i_exp_pc),
    .i_max_cycles(i_max_cycles), .i_load_ir(i_load_ir), .i_halt(i_halt),
    .i_pc(i_pc), .i_opcode(i_opcode), .i_alu_out(i_alu_out),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
    .o_fail_code(o_fail_code), .o_final_pc(o_final_pc),
    .o_instr_count(o_instr_count), .i_tr_rd_en(i_tr_rd_en),
    .o_tr_rd_valid(o_tr_rd_valid), .o_tr_rd_data(o_tr_rd_data),
    .o_tr_count(o_tr_count), .o_tr_overflow(o_tr_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] epc, input logic [15:0] maxc);
    i_start = 1'b1; i_exp_pc = epc; i_max_cycles = maxc;
    tick();
    i_start = 1'b0;
  endtask

  task automatic pulse_ir(input logic [4:0] p, input logic [2:0] op, input logic [7:0] alu);
    i_load_ir = 1'b1; i_pc = p; i_opcode = op; i_alu_out = alu;
    tick();
    i_load_ir = 1'b0;
    tick();
  endtask

  task automatic do_halt(input logic [4:0] p);
    i_pc = p; i_halt = 1'b1;
    tick();
    i_halt = 1'b0;
  endtask

  task automatic pop();
    i_tr_rd_en = 1'b1;
    tick();
    i_tr_rd_en = 1'b0;
  endtask

  function automatic logic [15:0] ent(input logic [4:0] p, input logic [2:0] op, input logic [7:0] alu);
    trace_entry_t e;
    e.pc = p; e.opcode = op; e.alu_out = alu;
    return e;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  o_busy, 0);
    chk({tag, "_done"},  o_done, 0);
    chk({tag, "_pass"},  o_pass, 0);
    chk({tag, "_fc"},    o_fail_code, 0);
    chk({tag, "_fpc"},   o_final_pc, 0);
    chk({tag, "_icnt"},  o_instr_count, 0);
    chk({tag, "_trcnt"}, o_tr_count, 0);
    chk({tag, "_ovf"},   o_tr_overflow, 0);
    chk({tag, "_rdv"},   o_tr_rd_valid, 0);
    chk({tag, "_rdd"},   o_tr_rd_data, 0);
  endtask

  initial begin
    int n;
    i_rst = 1'b0; i_start = 1'b0; i_load_ir = 1'b0; i_halt = 1'b0; i_tr_rd_en = 1'b0;
    i_exp_pc = '0; i_pc = '0; i_max_cycles = '0; i_opcode = '0; i_alu_out = '0;
    tick(); tick();
    chk_all_zero("rst");
    i_rst = 1'b1;
    tick();

    // Passing run: 12 fetches then halt at the expected PC.
    do_start(5'h17, 16'd1000);
    chk("t1_busy", o_busy, 1);
    chk("t1_done0", o_done, 0);
    for (int k = 1; k <= 12; k++) pulse_ir(5'(k), 3'(k), 8'(k * 3));
    do_halt(5'h17);
    chk("t1_done", o_done, 1);
    chk("t1_busy0", o_busy, 0);
    chk("t1_pass", o_pass, 1);
    chk("t1_fc", o_fail_code, 0);
    chk("t1_icnt", o_instr_count, 12);
    chk("t1_fpc", o_final_pc, 5'h17);
    chk("t1_trcnt", o_tr_count, 12);
    pop();
    chk("t1_rdv", o_tr_rd_valid, 1);
    chk("t1_rdd", o_tr_rd_data, ent(5'd1, 3'd1, 8'd3));
    chk("t1_hold", o_done, 1);

    // PC mismatch at halt; new start clears trace and counters.
    do_start(5'h10, 16'd0);
    chk("t2_trclr", o_tr_count, 0);
    do_halt(5'h0C);
    chk("t2_done", o_done, 1);
    chk("t2_pass", o_pass, 0);
    chk("t2_fc", o_fail_code, 1);
    chk("t2_fpc", o_final_pc, 5'h0C);
    chk("t2_icnt", o_instr_count, 0);

    // Watchdog: 100-cycle budget, done counted in edges from start sample.
    i_pc = 5'h09;
    i_start = 1'b1; i_exp_pc = 5'h00; i_max_cycles = 16'd100;
    n = 0;
    do begin
      tick(); n++;
      i_start = 1'b0;
    end while (!o_done && n < 300);
    chk("t3_lat", n, 101);
    chk("t3_fc", o_fail_code, 2);
    chk("t3_pass", o_pass, 0);
    chk("t3_fpc", o_final_pc, 5'h09);

    // Overflow: 20 captures into a 16-deep buffer keep pc 4..19.
    do_start(5'h00, 16'd0);
    for (int k = 0; k < 20; k++) pulse_ir(5'(k), 3'(k), 8'(k + 100));
    chk("t4_trcnt", o_tr_count, 16);
    chk("t4_ovf", o_tr_overflow, 1);
    chk("t4_icnt", o_instr_count, 20);
    for (int k = 4; k < 20; k++) begin
      pop();
      chk("t4_rdv", o_tr_rd_valid, 1);
      chk("t4_rdd", o_tr_rd_data, ent(5'(k), 3'(k), 8'(k + 100)));
    end
    pop();
    chk("t4_empty_rdv", o_tr_rd_valid, 0);
    chk("t4_empty_cnt", o_tr_count, 0);
    do_halt(5'h00);

    // Pop and push on a full buffer; start during RUN is ignored.
    do_start(5'h00, 16'd0);
    for (int k = 0; k < 16; k++) pulse_ir(5'(k), 3'(k), 8'(k));
    chk("t5_full", o_tr_count, 16);
    i_load_ir = 1'b1; i_pc = 5'd20; i_opcode = 3'd5; i_alu_out = 8'hAA; i_tr_rd_en = 1'b1;
    tick();
    i_load_ir = 1'b0; i_tr_rd_en = 1'b0;
    chk("t5_pp_rdv", o_tr_rd_valid, 1);
    chk("t5_pp_rdd", o_tr_rd_data, ent(5'd0, 3'd0, 8'd0));
    chk("t5_pp_cnt", o_tr_count, 16);
    chk("t5_pp_ovf", o_tr_overflow, 0);
    tick();
    pop();
    chk("t5_next", o_tr_rd_data, ent(5'd1, 3'd1, 8'd1));
    do_start(5'h1F, 16'd3);
    chk("t5_ign_busy", o_busy, 1);
    chk("t5_ign_icnt", o_instr_count, 17);
    chk("t5_ign_trcnt", o_tr_count, 15);
    tick(); tick(); tick(); tick();
    chk("t5_ign_wdog", o_done, 0);
    do_halt(5'h00);
    chk("t5_end", o_pass, 1);

    // Halt edge on the exact watchdog-expiry cycle: halt wins.
    do_start(5'h07, 16'd10);
    repeat (9) tick();
    chk("t6_pre", o_done, 0);
    do_halt(5'h07);
    chk("t6_done", o_done, 1);
    chk("t6_pass", o_pass, 1);
    chk("t6_fc", o_fail_code, 0);

    // Halt already high at start is not an edge; watchdog ends the run.
    i_halt = 1'b1; i_pc = 5'h03;
    do_start(5'h03, 16'd5);
    n = 0;
    while (!o_done && n < 50) begin tick(); n++; end
    chk("t7_fc", o_fail_code, 2);
    chk("t7_lat", n, 5);
    i_halt = 1'b0;

    // Reset mid-run after 5 captures, then a clean run.
    do_start(5'h00, 16'd0);
    for (int k = 0; k < 5; k++) pulse_ir(5'(k + 2), 3'd1, 8'(k));
    pop();
    i_rst = 1'b0;
    tick();
    i_rst = 1'b1;
    chk_all_zero("t8");
    do_start(5'h03, 16'd0);
    pulse_ir(5'd1, 3'd2, 8'd9);
    pulse_ir(5'd2, 3'd3, 8'd8);
    do_halt(5'h03);
    chk("t8_pass", o_pass, 1);
    chk("t8_icnt", o_instr_count, 2);
    chk("t8_trcnt", o_tr_count, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
